mem_word_sequencer: RTL
=======================

Name: mem_word_sequencer

Overview:
- Multi-cycle sequencer that moves one DATA_W-bit word between the datapath and a BYTE_W-wide memory, one byte per cycle.
- It replaces the fixed two-byte low/high split on the memory write path and the IR low/high load with a single block, parametrised in word width, byte width and byte order.
- Sits between the ALU/register side and the Memory block; it drives Mem_CS, Mem_WR and the address for the whole transfer.

Parameters:
- DATA_W, 16, word width; must be an integer multiple of BYTE_W.
- BYTE_W, 8, memory data width.
- ADDR_W, 16, memory address width.
- BIG_ENDIAN, 0, 0 = byte 0 at lowest address is bits [BYTE_W-1:0]; 1 = byte 0 at lowest address is the most significant byte.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  request a transfer; sampled on rising edge.
- Write  in  1  1 = word write to memory, 0 = word read; latched at Start.
- Abort  in  1  cancel an in-progress transfer.
- BaseAddr  in  ADDR_W  address of first byte; latched at Start.
- WrData  in  DATA_W  word to write; latched at Start.
- Busy  out  1  high while bytes are being transferred.
- Done  out  1  one-cycle completion pulse.
- RdData  out  DATA_W  last completed read word.
- Mem_CS  out  1  memory chip select, active-low.
- Mem_WR  out  1  1 = memory write this cycle.
- Mem_Addr  out  ADDR_W  byte address.
- Mem_DataOut  out  BYTE_W  byte to memory.
- Mem_DataIn  in  BYTE_W  byte from memory; combinational read, valid in the same cycle as Mem_Addr.

Behaviour:
- NBYTES = DATA_W/BYTE_W. Elaboration error if DATA_W % BYTE_W != 0.
- States:
  - IDLE: waiting for Start.
  - XFER: transferring bytes; byte counter idx runs 0..NBYTES-1.
  - DONE: one cycle, asserts Done.
- Transitions:
  - IDLE or DONE with Start=1: latch Write, BaseAddr and WrData; idx <= 0; go to XFER.
  - XFER with idx = NBYTES-1 and Abort=0: go to DONE.
  - XFER with Abort=1: go to IDLE. No Done pulse; RdData unchanged; bytes already written stay written.
  - DONE with Start=0: go to IDLE. Back-to-back Start from DONE is accepted with no idle cycle.
- Start while in XFER is ignored.
- Latency: Start sampled at edge T -> XFER for cycles T+1..T+NBYTES -> Done=1 in cycle T+NBYTES+1.
- Outputs are combinational from registered state:
  - Busy = (state == XFER).
  - Done = (state == DONE).
  - Mem_CS = 0 only in XFER.
  - Mem_WR = latched Write AND in XFER.
  - Mem_Addr = latched BaseAddr + idx, modulo 2^ADDR_W. Wrap is silent: base 0xFFFF continues at 0x0000. In IDLE/DONE, Mem_Addr = latched BaseAddr.
- Lane mapping: lane(idx) = idx if BIG_ENDIAN = 0, else NBYTES-1-idx. Lane k occupies bits [k*BYTE_W +: BYTE_W].
- Write transfer: Mem_DataOut = latched WrData lane(idx) during XFER, 0 otherwise.
- Read transfer: each XFER edge stores Mem_DataIn into shadow-register lane lane(idx). RdData is loaded from the shadow register on the XFER->DONE edge only. Write transfers never change RdData.
- Abort has priority over completion on the last byte.
- Reset, at any time including mid-transfer: state IDLE, idx 0, latched fields 0, shadow 0, RdData 0.
  - Resulting outputs: Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Addr=0, Mem_DataOut=0.
  - An interrupted write may leave a partially written word in memory.

Decomposition:
- Package mem_seq_pkg:
  - state enum {IDLE, XFER, DONE};
  - function computing NBYTES;
  - function lane_index(idx, nbytes, big_endian).
- Sub-module byte_lane_mux:
  - extracts lane k from a word (write path);
  - inserts a byte into lane k of a word (read path).
- Everything else stays in mem_word_sequencer.

Test Plan:
- Defaults, LE write: Start with Write=1, BaseAddr=0x0010, WrData=0xABCD -> XFER cycle 1 drives Addr=0x0010 Data=0xCD WR=1 CS=0; cycle 2 drives 0x0011/0xAB; Done pulses in the next cycle with Busy=0.
- BIG_ENDIAN=1 read from 0x0020, memory holds [0x0020]=0x12 and [0x0021]=0x34 -> RdData=0x1234 in the Done cycle; Mem_WR stays 0 throughout.
- Wrap: read from BaseAddr=0xFFFF -> Mem_Addr sequence 0xFFFF then 0x0000; Done after 2 XFER cycles.
- Abort: Abort=1 in the first XFER cycle of a read, with RdData previously 0x5A5A -> next cycle is IDLE, no Done, RdData stays 0x5A5A. Start is ignored while Busy.
- Reset mid-write: assert Reset asynchronously during XFER of a write -> Busy=0, Mem_CS=1, Mem_WR=0 and RdData=0 immediately, without waiting for a clock edge. After release, a new Start works normally.
- DATA_W=32, BYTE_W=8, LE: back-to-back write of 0xDEADBEEF to 0x0100 then read from 0x0100 (Start held in the DONE cycle) -> bytes written EF,BE,AD,DE at 0x0100..0x0103; read returns 0xDEADBEEF; exactly 4 XFER cycles per transfer.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the word/byte memory sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of memory bytes that make up one datapath word.
  function automatic int calc_nbytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Word lane touched by transfer step idx; big-endian puts the MSB at the lowest address.
  function automatic int lane_index(input int idx, input int nbytes, input bit big_endian);
    return big_endian ? (nbytes - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/mem_word_sequencer_byte_lane_mux.sv
// Byte-lane extract (write path) and byte-lane insert (read path) for one word.
module byte_lane_mux
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int LANE_W = 1
) (
  input  logic [DATA_W-1:0] ext_word_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [BYTE_W-1:0] ext_byte_o,
  input  logic [DATA_W-1:0] ins_word_i,
  input  logic [BYTE_W-1:0] ins_byte_i,
  output logic [DATA_W-1:0] ins_word_o
);

  localparam int NBYTES = calc_nbytes(DATA_W, BYTE_W);

  // Select the addressed lane out of the outgoing word.
  always_comb begin
    ext_byte_o = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (lane_i == LANE_W'(k)) ext_byte_o = ext_word_i[k*BYTE_W +: BYTE_W];
    end
  end

  // Replace the addressed lane of the incoming word, keep the others.
  always_comb begin
    ins_word_o = ins_word_i;
    for (int k = 0; k < NBYTES; k++) begin
      if (lane_i == LANE_W'(k)) ins_word_o[k*BYTE_W +: BYTE_W] = ins_byte_i;
    end
  end

endmodule

// File: rtl/mem_word_sequencer.sv
// Moves one DATA_W word to/from a BYTE_W-wide memory, one byte per clock.
//
// state | meaning
// IDLE  | waiting for Start
// XFER  | one byte per cycle, idx 0..NBYTES-1, memory selected
// DONE  | single-cycle completion, Done high
module mem_word_sequencer
  import mem_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int BYTE_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              Start_i,
  input  logic              Write_i,
  input  logic              Abort_i,
  input  logic [ADDR_W-1:0] BaseAddr_i,
  input  logic [DATA_W-1:0] WrData_i,
  output logic              Busy_o,
  output logic              Done_o,
  output logic [DATA_W-1:0] RdData_o,
  output logic              Mem_CS_o,
  output logic              Mem_WR_o,
  output logic [ADDR_W-1:0] Mem_Addr_o,
  output logic [BYTE_W-1:0] Mem_DataOut_o,
  input  logic [BYTE_W-1:0] Mem_DataIn_i
);

  localparam int NBYTES = calc_nbytes(DATA_W, BYTE_W);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
    $error("mem_word_sequencer: DATA_W must be a multiple of BYTE_W");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IDX_W-1:0]    lane;
  logic [BYTE_W-1:0]   wr_byte;
  logic [DATA_W-1:0]   shadow_ins;

  assign lane = IDX_W'(lane_index(int'(idx_q), NBYTES, BIG_ENDIAN != 0));

  byte_lane_mux #(
    .DATA_W(DATA_W),
    .BYTE_W(BYTE_W),
    .LANE_W(IDX_W)
  ) u_lane_mux (
    .ext_word_i(wdata_q),
    .lane_i    (lane),
    .ext_byte_o(wr_byte),
    .ins_word_i(shadow_q),
    .ins_byte_i(Mem_DataIn_i),
    .ins_word_o(shadow_ins)
  );

  // State and datapath registers; reset clears everything including the last read word.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      write_q  <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state: accept Start from IDLE/DONE, step bytes, abort wins over completion.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start_i) begin
          write_d = Write_i;
          base_d  = BaseAddr_i;
          wdata_d = WrData_i;
          idx_d   = '0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (Abort_i) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          if (!write_q) shadow_d = shadow_ins;
          if (idx_q == LAST_IDX) begin
            // The last byte goes straight into RdData along with the earlier lanes.
            if (!write_q) rdata_d = shadow_ins;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side outputs decoded from registered state only.
  always_comb begin
    Busy_o        = (state_q == XFER);
    Done_o        = (state_q == DONE);
    Mem_CS_o      = !(state_q == XFER);
    Mem_WR_o      = write_q && (state_q == XFER);
    Mem_Addr_o    = (state_q == XFER) ? (base_q + ADDR_W'(idx_q)) : base_q;
    Mem_DataOut_o = (state_q == XFER) ? wr_byte : '0;
    RdData_o      = rdata_q;
  end

endmodule
